// File: rtl/lift_gate_deadtime.sv
// Lift motor gate driver: per-leg dead-time insertion, fault latching and OPB control/status registers.
// Latency: PWM_IN pin to GATE_OUT is 3 OPB_CLK cycles (2 sync + 1 state); any fault or EN=0 forces gates low on the next edge.
module lift_gate_deadtime #(
  parameter int DT_WIDTH   = 8,
  parameter int DT_DEFAULT = 16
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic [5:0]  PWM_IN,
  input  logic        FAULT_IN,
  input  logic [31:0] DT_ADDR,
  input  logic [31:0] DT_DI,
  input  logic        DT_WE,
  input  logic        DT_RE,
  output logic [31:0] DT_DO,
  output logic [5:0]  GATE_OUT,
  output logic        FAULT_IRQ
);

  typedef enum logic [1:0] {
    S_OFF  = 2'b00,
    S_LO   = 2'b01,
    S_HI   = 2'b10,
    S_DEAD = 2'b11
  } leg_state_t;

  logic [5:0]          pwm_s1_q, pwm_s2_q;
  logic                fin_s1_q, fin_s2_q;
  logic                en_q;
  logic [DT_WIDTH-1:0] dt_q;
  logic [3:0]          status_q, status_d;
  leg_state_t          state_q [3];
  leg_state_t          state_d [3];
  logic [DT_WIDTH-1:0] cnt_q [3];
  logic [DT_WIDTH-1:0] cnt_d [3];
  logic [1:0]          tgt_q [3];
  logic [1:0]          tgt_d [3];
  logic [5:0]          gate_q, gate_d;

  logic [5:0]          req;
  logic                fin;
  logic [3:0]          w1c;
  logic [2:0]          conflict;
  logic                force_off;
  logic [DT_WIDTH-1:0] dt_load;
  logic                unused_ok;

  assign req       = pwm_s2_q;
  assign fin       = fin_s2_q;
  assign unused_ok = ^{DT_ADDR[31:3], DT_DI};

  always_comb begin
    w1c = (DT_WE && DT_ADDR[2:0] == 3'd2) ? DT_DI[3:0] : 4'b0;
    for (int l = 0; l < 3; l++) begin
      conflict[l] = req[2*l+1] & req[2*l];
    end
    // Set terms are ORed in after the clear, so a simultaneous set wins.
    status_d[2:0] = (status_q[2:0] & ~w1c[2:0]) | conflict;
    status_d[3]   = (status_q[3] & ~w1c[3]) | fin;
    force_off     = (|status_d) | ~en_q;
    dt_load       = (dt_q == '0) ? DT_WIDTH'(1) : dt_q;

    gate_d = 6'b0;
    for (int l = 0; l < 3; l++) begin
      state_d[l] = state_q[l];
      cnt_d[l]   = cnt_q[l];
      tgt_d[l]   = tgt_q[l];
      if (force_off) begin
        state_d[l] = S_OFF;
        cnt_d[l]   = '0;
        tgt_d[l]   = 2'b00;
      end else begin
        case (state_q[l])
          S_OFF: begin
            if (req[2*l +: 2] == 2'b10)      state_d[l] = S_HI;
            else if (req[2*l +: 2] == 2'b01) state_d[l] = S_LO;
          end
          S_HI, S_LO: begin
            if (req[2*l +: 2] != ((state_q[l] == S_HI) ? 2'b10 : 2'b01)) begin
              state_d[l] = S_DEAD;
              cnt_d[l]   = dt_load;
              tgt_d[l]   = req[2*l +: 2];
            end
          end
          default: begin
            // Target follows the request but the running count is never reloaded.
            tgt_d[l] = req[2*l +: 2];
            if (cnt_q[l] <= DT_WIDTH'(1)) begin
              cnt_d[l] = '0;
              case (tgt_q[l])
                2'b10:   state_d[l] = S_HI;
                2'b01:   state_d[l] = S_LO;
                default: state_d[l] = S_OFF;
              endcase
            end else begin
              cnt_d[l] = cnt_q[l] - DT_WIDTH'(1);
            end
          end
        endcase
      end
      if (state_d[l] == S_HI)      gate_d[2*l +: 2] = 2'b10;
      else if (state_d[l] == S_LO) gate_d[2*l +: 2] = 2'b01;
    end
  end

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      pwm_s1_q <= 6'b0;
      pwm_s2_q <= 6'b0;
      fin_s1_q <= 1'b0;
      fin_s2_q <= 1'b0;
      en_q     <= 1'b0;
      dt_q     <= DT_WIDTH'(DT_DEFAULT);
      status_q <= 4'b0;
      gate_q   <= 6'b0;
      for (int l = 0; l < 3; l++) begin
        state_q[l] <= S_OFF;
        cnt_q[l]   <= '0;
        tgt_q[l]   <= 2'b00;
      end
    end else begin
      pwm_s1_q <= PWM_IN;
      pwm_s2_q <= pwm_s1_q;
      fin_s1_q <= FAULT_IN;
      fin_s2_q <= fin_s1_q;
      if (DT_WE && DT_ADDR[2:0] == 3'd0) en_q <= DT_DI[0];
      if (DT_WE && DT_ADDR[2:0] == 3'd1) dt_q <= DT_DI[DT_WIDTH-1:0];
      status_q <= status_d;
      gate_q   <= gate_d;
      for (int l = 0; l < 3; l++) begin
        state_q[l] <= state_d[l];
        cnt_q[l]   <= cnt_d[l];
        tgt_q[l]   <= tgt_d[l];
      end
    end
  end

  always_comb begin
    DT_DO = 32'b0;
    if (DT_RE) begin
      case (DT_ADDR[2:0])
        3'd0:    DT_DO = {31'b0, en_q};
        3'd1:    DT_DO = 32'(dt_q);
        3'd2:    DT_DO = {22'b0, gate_q, status_q};
        3'd3:    DT_DO = {26'b0, pwm_s2_q};
        default: DT_DO = 32'b0;
      endcase
    end
  end

  assign GATE_OUT  = gate_q;
  assign FAULT_IRQ = |status_q;

endmodule

// File: tb/tb_lift_gate_deadtime.sv
// Directed bench for lift_gate_deadtime: inputs driven on the falling edge, outputs sampled before the next rising edge.
module tb_lift_gate_deadtime;

  logic        OPB_CLK = 1'b0;
  logic        OPB_RST;
  logic [5:0]  PWM_IN;
  logic        FAULT_IN;
  logic [31:0] DT_ADDR;
  logic [31:0] DT_DI;
  logic        DT_WE;
  logic        DT_RE;
  logic [31:0] DT_DO;
  logic [5:0]  GATE_OUT;
  logic        FAULT_IRQ;

  int n_checks = 0;
  int n_errors = 0;

  lift_gate_deadtime #(.DT_WIDTH(8), .DT_DEFAULT(16)) dut (
    .OPB_CLK   (OPB_CLK),
    .OPB_RST   (OPB_RST),
    .PWM_IN    (PWM_IN),
    .FAULT_IN  (FAULT_IN),
    .DT_ADDR   (DT_ADDR),
    .DT_DI     (DT_DI),
    .DT_WE     (DT_WE),
    .DT_RE     (DT_RE),
    .DT_DO     (DT_DO),
    .GATE_OUT  (GATE_OUT),
    .FAULT_IRQ (FAULT_IRQ)
  );

  always #5 OPB_CLK = ~OPB_CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge OPB_CLK);
    @(negedge OPB_CLK);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    DT_ADDR = a;
    DT_DI   = d;
    DT_WE   = 1'b1;
    step();
    DT_WE   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    DT_ADDR = a;
    DT_RE   = 1'b1;
    #1;
    chk(tag, DT_DO, exp);
    DT_RE   = 1'b0;
  endtask

  initial begin
    OPB_RST  = 1'b1;
    PWM_IN   = 6'b0;
    FAULT_IN = 1'b0;
    DT_ADDR  = 32'b0;
    DT_DI    = 32'b0;
    DT_WE    = 1'b0;
    DT_RE    = 1'b0;
    repeat (2) @(negedge OPB_CLK);
    chk("rst_gate", {26'b0, GATE_OUT}, 32'h0);
    chk("rst_irq", {31'b0, FAULT_IRQ}, 32'h0);
    OPB_RST = 1'b0;
    step();
    rd("rst_ctrl", 32'd0, 32'h0);
    rd("rst_dt", 32'd1, 32'h10);
    rd("rst_status", 32'd2, 32'h0);
    rd("rst_unmapped", 32'd5, 32'h0);
    DT_ADDR = 32'd1;
    #1 chk("re_low_do", DT_DO, 32'h0);

    // 1: enable and drive A high, B low, C high
    wr(32'd0, 32'd1);
    rd("t1_ctrl", 32'd0, 32'h1);
    PWM_IN = 6'b100110;
    step(); step();
    chk("t1_lat2", {26'b0, GATE_OUT}, 32'h00);
    step();
    chk("t1_lat3", {26'b0, GATE_OUT}, 32'h26);
    chk("t1_irq", {31'b0, FAULT_IRQ}, 32'h0);
    rd("t1_input", 32'd3, 32'h26);

    // 2: dead time 4 on leg A high->low
    wr(32'd1, 32'd4);
    PWM_IN = 6'b010110;
    step(); step();
    chk("t2_pre", {26'b0, GATE_OUT}, 32'h26);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t2_dead%0d", i), {26'b0, GATE_OUT}, 32'h06);
    end
    step();
    chk("t2_lo", {26'b0, GATE_OUT}, 32'h16);

    // 3: dead time 0 behaves as one cycle on leg C
    wr(32'd1, 32'd0);
    PWM_IN = 6'b010101;
    step(); step();
    chk("t3_pre", {26'b0, GATE_OUT}, 32'h16);
    step();
    chk("t3_dead", {26'b0, GATE_OUT}, 32'h14);
    step();
    chk("t3_lo", {26'b0, GATE_OUT}, 32'h15);

    // 3b: leg B glitch 01->10->01 inside a 4-cycle dead window
    wr(32'd1, 32'd4);
    PWM_IN = 6'b011001;
    step();
    PWM_IN = 6'b010101;
    step();
    chk("t3b_pre", {26'b0, GATE_OUT}, 32'h15);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t3b_dead%0d", i), {26'b0, GATE_OUT}, 32'h11);
    end
    step();
    chk("t3b_end", {26'b0, GATE_OUT}, 32'h15);
    step();
    chk("t3b_hold", {26'b0, GATE_OUT}, 32'h15);

    // 4: leg B shoot-through request
    PWM_IN = 6'b011101;
    step(); step();
    chk("t4_pre", {26'b0, GATE_OUT}, 32'h15);
    step();
    chk("t4_gate", {26'b0, GATE_OUT}, 32'h00);
    chk("t4_irq", {31'b0, FAULT_IRQ}, 32'h1);
    rd("t4_status", 32'd2, 32'h002);
    wr(32'd2, 32'd2);
    rd("t4_status_held", 32'd2, 32'h002);
    PWM_IN = 6'b010101;
    step(); step();
    chk("t4_still_off", {26'b0, GATE_OUT}, 32'h00);
    wr(32'd2, 32'd2);
    chk("t4_irq_clr", {31'b0, FAULT_IRQ}, 32'h0);
    chk("t4_resume", {26'b0, GATE_OUT}, 32'h15);
    rd("t4_status_gate", 32'd2, 32'h150);

    // 5: external fault
    FAULT_IN = 1'b1;
    step(); step();
    chk("t5_pre", {26'b0, GATE_OUT}, 32'h15);
    step();
    chk("t5_gate", {26'b0, GATE_OUT}, 32'h00);
    rd("t5_status", 32'd2, 32'h008);
    wr(32'd2, 32'd8);
    rd("t5_status_held", 32'd2, 32'h008);
    FAULT_IN = 1'b0;
    step(); step();
    rd("t5_status_latched", 32'd2, 32'h008);
    wr(32'd2, 32'd8);
    chk("t5_irq_clr", {31'b0, FAULT_IRQ}, 32'h0);
    chk("t5_resume", {26'b0, GATE_OUT}, 32'h15);
    rd("t5_status_gate", 32'd2, 32'h150);

    // 6: reset in the middle of a long dead window
    wr(32'd1, 32'h20);
    PWM_IN = 6'b100101;
    step(); step(); step();
    chk("t6_dead", {26'b0, GATE_OUT}, 32'h05);
    step();
    chk("t6_dead2", {26'b0, GATE_OUT}, 32'h05);
    OPB_RST = 1'b1;
    #1;
    chk("t6_gate_async", {26'b0, GATE_OUT}, 32'h00);
    chk("t6_irq", {31'b0, FAULT_IRQ}, 32'h0);
    rd("t6_dt", 32'd1, 32'h10);
    rd("t6_ctrl", 32'd0, 32'h0);
    rd("t6_input", 32'd3, 32'h0);
    @(negedge OPB_CLK);
    OPB_RST = 1'b0;
    step(); step(); step();
    chk("t6_disabled", {26'b0, GATE_OUT}, 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
